// File: rtl/tx_frame_sched.sv
// Round-robin symbol scheduler: frames NUM_CH byte streams as SOF, channel ID, payload, EOF
// for an 8b10b serializer, one symbol per serializer load slot.
module tx_frame_sched #(
  parameter int NUM_CH   = 4,
  parameter int MAX_LEN  = 256,
  parameter int MIN_IDLE = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NUM_CH-1:0]         s_valid_i,
  input  logic [8*NUM_CH-1:0]       s_data_i,
  input  logic [NUM_CH-1:0]         s_last_i,
  output logic [NUM_CH-1:0]         s_ready_o,
  input  logic                      sym_ena_i,
  output logic [8:0]                sym_o,
  output logic [$clog2(NUM_CH)-1:0] grant_o,
  output logic                      busy_o,
  output logic                      frame_err_o
);

  localparam int GW = $clog2(NUM_CH);
  localparam int CW = $clog2(MAX_LEN + 1);
  localparam int IW = $clog2(MIN_IDLE + 1);

  localparam logic [8:0] SYM_IDLE  = 9'h1BC;
  localparam logic [8:0] SYM_SOF   = 9'h1FB;
  localparam logic [8:0] SYM_EOF   = 9'h1FD;
  localparam logic [8:0] SYM_PAD   = 9'h1F7;
  localparam logic [8:0] SYM_ABORT = 9'h1FE;

  // Handshake: a byte on channel c transfers on a clock edge where
  // s_valid_i[c] && s_ready_o[c]; the source holds data/last stable until then.

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAYLOAD,
    ST_EOF,
    ST_ABORT,
    ST_DRAIN
  } state_t;

  state_t          state_q, state_d;
  logic [8:0]      sym_q, sym_d;
  logic [IW-1:0]   idle_cnt_q, idle_cnt_d;
  logic [CW-1:0]   byte_cnt_q, byte_cnt_d;
  logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic            busy_q, busy_d;
  logic            frame_err_q, frame_err_d;

  logic [GW-1:0]   rr_pick;
  logic [GW-1:0]   rr_next;
  logic [GW-1:0]   cand;
  logic            found;
  logic            g_valid;
  logic            g_last;
  logic [7:0]      g_data;
  logic [CW-1:0]   cnt_inc;

  // First valid channel at or above rr_ptr, wrapping.
  always_comb begin
    rr_pick = '0;
    found   = 1'b0;
    cand    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = GW'((int'(rr_ptr_q) + i) % NUM_CH);
      if (!found && s_valid_i[cand]) begin
        found   = 1'b1;
        rr_pick = cand;
      end
    end
  end

  assign rr_next = (grant_q == GW'(NUM_CH - 1)) ? '0 : grant_q + GW'(1);
  assign g_valid = s_valid_i[grant_q];
  assign g_last  = s_last_i[grant_q];
  assign g_data  = s_data_i[int'(grant_q)*8 +: 8];
  assign cnt_inc = byte_cnt_q + CW'(1);

  always_comb begin
    state_d     = state_q;
    sym_d       = sym_q;
    idle_cnt_d  = idle_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    busy_d      = busy_q;
    frame_err_d = 1'b0;
    s_ready_o   = '0;
    case (state_q)
      ST_IDLE: begin
        if (sym_ena_i) begin
          if (idle_cnt_q >= IW'(MIN_IDLE) && found) begin
            grant_d = rr_pick;
            sym_d   = SYM_SOF;
            busy_d  = 1'b1;
            state_d = ST_HDR;
          end else begin
            sym_d = SYM_IDLE;
            if (idle_cnt_q < IW'(MIN_IDLE)) idle_cnt_d = idle_cnt_q + IW'(1);
          end
        end
      end
      ST_HDR: begin
        if (sym_ena_i) begin
          sym_d      = {1'b0, 8'(grant_q)};
          byte_cnt_d = '0;
          state_d    = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        s_ready_o[grant_q] = sym_ena_i;
        if (sym_ena_i) begin
          if (g_valid) begin
            sym_d      = {1'b0, g_data};
            byte_cnt_d = cnt_inc;
            if (g_last) state_d = ST_EOF;
            else if (cnt_inc == CW'(MAX_LEN)) state_d = ST_ABORT;
          end else begin
            // Underrun: pad the slot, keep the byte count.
            sym_d = SYM_PAD;
          end
        end
      end
      ST_EOF: begin
        if (sym_ena_i) begin
          sym_d      = SYM_EOF;
          state_d    = ST_IDLE;
          idle_cnt_d = '0;
          busy_d     = 1'b0;
          rr_ptr_d   = rr_next;
        end
      end
      ST_ABORT: begin
        if (sym_ena_i) begin
          sym_d       = SYM_ABORT;
          frame_err_d = 1'b1;
          state_d     = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Discard the rest of the oversized packet at full clock rate.
        s_ready_o[grant_q] = 1'b1;
        if (sym_ena_i) sym_d = SYM_IDLE;
        if (g_valid && g_last) begin
          state_d    = ST_IDLE;
          idle_cnt_d = '0;
          busy_d     = 1'b0;
          rr_ptr_d   = rr_next;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      sym_q       <= SYM_IDLE;
      idle_cnt_q  <= IW'(MIN_IDLE);
      byte_cnt_q  <= '0;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sym_q       <= sym_d;
      idle_cnt_q  <= idle_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign sym_o       = sym_q;
  assign grant_o     = grant_q;
  assign busy_o      = busy_q;
  assign frame_err_o = frame_err_q;

endmodule

// File: tb/tb_tx_frame_sched.sv
// Directed bench for tx_frame_sched (NUM_CH=4, MAX_LEN=4, MIN_IDLE=2): per-channel byte
// sources, an expected-symbol queue checked on every load slot, and a final report.
module tb_tx_frame_sched;
  localparam int NUM_CH   = 4;
  localparam int MAX_LEN  = 4;
  localparam int MIN_IDLE = 2;

  logic                  clk_i = 1'b0;
  logic                  rst_ni;
  logic [NUM_CH-1:0]     s_valid_i;
  logic [8*NUM_CH-1:0]   s_data_i;
  logic [NUM_CH-1:0]     s_last_i;
  logic [NUM_CH-1:0]     s_ready_o;
  logic                  sym_ena_i;
  logic [8:0]            sym_o;
  logic [1:0]            grant_o;
  logic                  busy_o;
  logic                  frame_err_o;

  tx_frame_sched #(.NUM_CH(NUM_CH), .MAX_LEN(MAX_LEN), .MIN_IDLE(MIN_IDLE)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .s_valid_i   (s_valid_i),
    .s_data_i    (s_data_i),
    .s_last_i    (s_last_i),
    .s_ready_o   (s_ready_o),
    .sym_ena_i   (sym_ena_i),
    .sym_o       (sym_o),
    .grant_o     (grant_o),
    .busy_o      (busy_o),
    .frame_err_o (frame_err_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  int         checks = 0;
  int         failures = 0;
  int         err_cycles = 0;
  logic [8:0] exp_q[$];
  logic [8:0] last_exp = 9'h1BC;
  string      tag = "init";

  // source entries: {bubble, last, data}
  logic [9:0] src_mem[NUM_CH][32];
  int         src_rd[NUM_CH];
  int         src_wr[NUM_CH];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // driver tasks
  task automatic push_byte(input int c, input logic [7:0] d, input logic last);
    src_mem[c][src_wr[c]] = {1'b0, last, d};
    src_wr[c]++;
  endtask

  task automatic push_bubble(input int c);
    src_mem[c][src_wr[c]] = 10'h200;
    src_wr[c]++;
  endtask

  task automatic clear_sources();
    for (int c = 0; c < NUM_CH; c++) begin
      src_rd[c] = 0;
      src_wr[c] = 0;
    end
  endtask

  task automatic ex(input logic [8:0] s);
    exp_q.push_back(s);
  endtask

  task automatic ex_idles(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(9'h1BC);
  endtask

  // One clock: drive sources, resolve handshakes, score the loaded symbol.
  task automatic step(input logic ena);
    logic [NUM_CH-1:0] fire;
    logic [NUM_CH-1:0] bub;
    logic [9:0]        ent;
    logic [8:0]        e;
    sym_ena_i = ena;
    bub = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      s_valid_i[c]       = 1'b0;
      s_last_i[c]        = 1'b0;
      s_data_i[8*c +: 8] = 8'h00;
      if (src_rd[c] != src_wr[c]) begin
        ent = src_mem[c][src_rd[c]];
        if (ent[9]) bub[c] = 1'b1;
        else begin
          s_valid_i[c]       = 1'b1;
          s_last_i[c]        = ent[8];
          s_data_i[8*c +: 8] = ent[7:0];
        end
      end
    end
    @(negedge clk_i);
    fire = s_valid_i & s_ready_o;
    @(posedge clk_i);
    #1;
    for (int c = 0; c < NUM_CH; c++)
      if (fire[c] || (bub[c] && ena)) src_rd[c]++;
    if (frame_err_o) err_cycles++;
    if (ena) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({tag, "_sym"}, 32'(sym_o), 32'(e));
        last_exp = e;
      end
    end else begin
      check({tag, "_hold"}, 32'(sym_o), 32'(last_exp));
    end
  endtask

  task automatic run_exp(input logic gaps);
    while (exp_q.size() > 0) begin
      step(1'b1);
      if (gaps) step(1'b0);
    end
  endtask

  initial begin
    rst_ni    = 1'b0;
    sym_ena_i = 1'b0;
    s_valid_i = '0;
    s_data_i  = '0;
    s_last_i  = '0;
    clear_sources();

    // 1: reset values, then idle commas with no requests
    tag = "t1";
    #12;
    check("t1_rst_sym", 32'(sym_o), 32'h1BC);
    check("t1_rst_busy", 32'(busy_o), 32'h0);
    check("t1_rst_ready", 32'(s_ready_o), 32'h0);
    check("t1_rst_grant", 32'(grant_o), 32'h0);
    check("t1_rst_err", 32'(frame_err_o), 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    ex_idles(5);
    run_exp(1'b0);
    check("t1_busy", 32'(busy_o), 32'h0);
    check("t1_ready", 32'(s_ready_o), 32'h0);

    // 2: two-byte frame on ch2, then rr_ptr=3 favours ch3 over ch1
    tag = "t2";
    push_byte(2, 8'hAA, 1'b0);
    push_byte(2, 8'hBB, 1'b1);
    ex(9'h1FB);
    run_exp(1'b0);
    check("t2_busy_sof", 32'(busy_o), 32'h1);
    check("t2_grant", 32'(grant_o), 32'h2);
    ex(9'h002); ex(9'h0AA); ex(9'h0BB); ex(9'h1FD); ex_idles(2);
    run_exp(1'b0);
    check("t2_busy_end", 32'(busy_o), 32'h0);
    tag = "t2rr";
    push_byte(1, 8'h31, 1'b1);
    push_byte(3, 8'h33, 1'b1);
    ex(9'h1FB); ex(9'h003); ex(9'h033); ex(9'h1FD); ex_idles(2);
    ex(9'h1FB); ex(9'h001); ex(9'h031); ex(9'h1FD); ex_idles(2);
    run_exp(1'b0);

    // 3: ch0/ch1 back-to-back 1-byte packets, slots separated by idle clocks
    tag = "t3";
    push_byte(0, 8'h10, 1'b1);
    push_byte(0, 8'h11, 1'b1);
    push_byte(1, 8'h20, 1'b1);
    push_byte(1, 8'h21, 1'b1);
    ex(9'h1FB); ex(9'h000); ex(9'h010); ex(9'h1FD); ex_idles(2);
    ex(9'h1FB); ex(9'h001); ex(9'h020); ex(9'h1FD); ex_idles(2);
    ex(9'h1FB); ex(9'h000); ex(9'h011); ex(9'h1FD); ex_idles(2);
    ex(9'h1FB); ex(9'h001); ex(9'h021); ex(9'h1FD); ex_idles(2);
    run_exp(1'b1);

    // 4: ch1 underruns for 3 slots mid-payload
    tag = "t4";
    push_byte(1, 8'h41, 1'b0);
    push_bubble(1);
    push_bubble(1);
    push_bubble(1);
    push_byte(1, 8'h42, 1'b0);
    push_byte(1, 8'h43, 1'b1);
    ex(9'h1FB); ex(9'h001); ex(9'h041);
    ex(9'h1F7); ex(9'h1F7); ex(9'h1F7);
    ex(9'h042); ex(9'h043); ex(9'h1FD); ex_idles(2);
    run_exp(1'b0);
    check("t4_err", 32'(err_cycles), 32'h0);

    // 5a: 6-byte packet over MAX_LEN=4 is aborted and drained
    tag = "t5a";
    push_byte(2, 8'h51, 1'b0);
    push_byte(2, 8'h52, 1'b0);
    push_byte(2, 8'h53, 1'b0);
    push_byte(2, 8'h54, 1'b0);
    push_byte(2, 8'h55, 1'b0);
    push_byte(2, 8'h56, 1'b1);
    ex(9'h1FB); ex(9'h002); ex(9'h051); ex(9'h052); ex(9'h053); ex(9'h054); ex(9'h1FE);
    run_exp(1'b0);
    check("t5a_err_pulse", 32'(frame_err_o), 32'h1);
    ex_idles(4);
    run_exp(1'b0);
    check("t5a_err_cycles", 32'(err_cycles), 32'h1);
    check("t5a_drained", 32'(src_wr[2] - src_rd[2]), 32'h0);
    check("t5a_busy", 32'(busy_o), 32'h0);

    // 5b: exactly MAX_LEN bytes with last is a legal frame
    tag = "t5b";
    push_byte(3, 8'h61, 1'b0);
    push_byte(3, 8'h62, 1'b0);
    push_byte(3, 8'h63, 1'b0);
    push_byte(3, 8'h64, 1'b1);
    ex(9'h1FB); ex(9'h003); ex(9'h061); ex(9'h062); ex(9'h063); ex(9'h064); ex(9'h1FD);
    ex_idles(2);
    run_exp(1'b0);
    check("t5b_err_cycles", 32'(err_cycles), 32'h1);

    // 6: asynchronous reset mid-payload, then a fresh frame
    tag = "t6";
    push_byte(0, 8'h71, 1'b0);
    push_byte(0, 8'h72, 1'b0);
    push_byte(0, 8'h73, 1'b1);
    ex(9'h1FB); ex(9'h000); ex(9'h071);
    run_exp(1'b0);
    check("t6_busy_pre", 32'(busy_o), 32'h1);
    #3;
    rst_ni = 1'b0;
    #1;
    check("t6_rst_sym", 32'(sym_o), 32'h1BC);
    check("t6_rst_ready", 32'(s_ready_o), 32'h0);
    check("t6_rst_busy", 32'(busy_o), 32'h0);
    clear_sources();
    sym_ena_i = 1'b0;
    s_valid_i = '0;
    last_exp  = 9'h1BC;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    push_byte(1, 8'h81, 1'b1);
    ex(9'h1FB); ex(9'h001); ex(9'h081); ex(9'h1FD); ex_idles(2);
    run_exp(1'b0);
    check("t6_grant", 32'(grant_o), 32'h1);
    check("t6_err_cycles", 32'(err_cycles), 32'h1);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
